// File: rtl/io_handshake_port.sv
// io_handshake_port
//   Peripheral-side endpoint for the accumulator processor's two byte-wide
//   device handshakes, each direction buffered by its own small FIFO.
//
//   TX path (host -> processor): the host pushes bytes with tx_wr. A 4-phase
//   device-side FSM presents the FIFO head on input_bus and raises in_dev_hs
//   until the processor acks. After the ack it waits for the ack to drop.
//
//   RX path (processor -> host): the processor strobes output_bus with out_stb
//   while out_dev_hs is high. The byte is queued and out_dev_ack pulses for
//   one cycle. The host reads the show-ahead head on rx_data and pops it with
//   rx_rd.
//
// Ports
//   g_clk       in   clock, rising edge
//   g_clr       in   asynchronous reset, active low
//   tx_data     in   host byte for the processor
//   tx_wr       in   push tx_data into the TX FIFO
//   tx_full     out  TX FIFO full
//   tx_ovf      out  sticky: tx_wr arrived while the TX FIFO was full
//   input_bus   out  byte presented to the processor
//   in_dev_hs   out  input data ready
//   in_dev_ack  in   processor has taken the byte
//   output_bus  in   byte driven by the processor
//   out_stb     in   processor write strobe
//   out_dev_hs  out  device ready to receive
//   out_dev_ack out  byte captured (one-cycle pulse)
//   rx_data     out  RX FIFO head (show-ahead)
//   rx_empty    out  RX FIFO empty
//   rx_rd       in   pop the RX FIFO head
//   rx_ovf      out  sticky: out_stb arrived while out_dev_hs was low

module io_handshake_port #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             g_clk,
   input  logic             g_clr,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_wr,
   output logic             tx_full,
   output logic             tx_ovf,
   output logic [WIDTH-1:0] input_bus,
   output logic             in_dev_hs,
   input  logic             in_dev_ack,
   input  logic [WIDTH-1:0] output_bus,
   input  logic             out_stb,
   output logic             out_dev_hs,
   output logic             out_dev_ack,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_empty,
   input  logic             rx_rd,
   output logic             rx_ovf
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] CntFull = CW'(DEPTH);

   typedef enum logic [1:0] {IIdle, IPresent, IRelease} tx_state_e;
   typedef enum logic [1:0] {OInit, OReady, OAck} rx_state_e;

   // ---------------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] tx_mem_q [DEPTH];
   logic [PW-1:0]    tx_wptr_q, tx_rptr_q;
   logic [CW-1:0]    tx_cnt_q;
   logic             tx_empty, tx_push, tx_pop, tx_load;
   logic             tx_ovf_q;

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == CntFull);
   assign tx_push  = tx_wr & ~tx_full;
   assign tx_ovf   = tx_ovf_q;

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         for (int i = 0; i < int'(DEPTH); i++) tx_mem_q[i] <= '0;
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
         tx_ovf_q  <= 1'b0;
      end else begin
         if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= tx_data;
            tx_wptr_q           <= tx_wptr_q + 1'b1;
         end
         if (tx_pop) tx_rptr_q <= tx_rptr_q + 1'b1;
         if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
         else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
         if (tx_wr && tx_full) tx_ovf_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // TX FSM: 4-phase handshake, device side
   // ---------------------------------------------------------------------------
   tx_state_e        tx_state_q, tx_state_d;
   logic [WIDTH-1:0] input_bus_q;

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         tx_state_q  <= IIdle;
         input_bus_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         if (tx_load) input_bus_q <= tx_mem_q[tx_rptr_q];
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_load    = 1'b0;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         IIdle: begin
            if (!tx_empty) begin
               tx_load    = 1'b1;
               tx_state_d = IPresent;
            end
         end
         IPresent: begin
            // The byte leaves the FIFO only once the processor has taken it.
            if (in_dev_ack) begin
               tx_pop     = 1'b1;
               tx_state_d = IRelease;
            end
         end
         IRelease: begin
            if (!in_dev_ack) tx_state_d = IIdle;
         end
         default: tx_state_d = IIdle;
      endcase
   end

   // Decoded from state so that reset drops it without waiting for a clock.
   assign in_dev_hs = (tx_state_q == IPresent);
   assign input_bus = input_bus_q;

   // ---------------------------------------------------------------------------
   // RX FIFO
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] rx_mem_q [DEPTH];
   logic [PW-1:0]    rx_wptr_q, rx_rptr_q;
   logic [CW-1:0]    rx_cnt_q;
   logic             rx_full, rx_push, rx_pop;
   logic             rx_ovf_q;

   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CntFull);
   assign rx_pop   = rx_rd & ~rx_empty;
   assign rx_data  = rx_mem_q[rx_rptr_q];
   assign rx_ovf   = rx_ovf_q;

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         for (int i = 0; i < int'(DEPTH); i++) rx_mem_q[i] <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
         rx_ovf_q  <= 1'b0;
      end else begin
         if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= output_bus;
            rx_wptr_q           <= rx_wptr_q + 1'b1;
         end
         if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
         if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
         else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
         if (out_stb && !out_dev_hs) rx_ovf_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // RX FSM: ready / ack, one byte per two cycles at most
   // ---------------------------------------------------------------------------
   rx_state_e rx_state_q, rx_state_d;

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) rx_state_q <= OInit;
      else        rx_state_q <= rx_state_d;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_push    = 1'b0;
      out_dev_hs = 1'b0;
      unique case (rx_state_q)
         OInit: rx_state_d = OReady;
         OReady: begin
            out_dev_hs = ~rx_full;
            if (out_stb && !rx_full) begin
               rx_push    = 1'b1;
               rx_state_d = OAck;
            end
         end
         OAck:    rx_state_d = OReady;
         default: rx_state_d = OInit;
      endcase
   end

   assign out_dev_ack = (rx_state_q == OAck);

endmodule

// File: tb/tb_io_handshake_port.sv
module tb_io_handshake_port;

   logic       g_clk;
   logic       g_clr;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_full;
   logic       tx_ovf;
   logic [7:0] input_bus;
   logic       in_dev_hs;
   logic       in_dev_ack;
   logic [7:0] output_bus;
   logic       out_stb;
   logic       out_dev_hs;
   logic       out_dev_ack;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic       rx_rd;
   logic       rx_ovf;

   int n_cmp = 0;
   int n_err = 0;

   io_handshake_port #(
      .DEPTH(4),
      .WIDTH(8)
   ) dut (
      .g_clk      (g_clk),
      .g_clr      (g_clr),
      .tx_data    (tx_data),
      .tx_wr      (tx_wr),
      .tx_full    (tx_full),
      .tx_ovf     (tx_ovf),
      .input_bus  (input_bus),
      .in_dev_hs  (in_dev_hs),
      .in_dev_ack (in_dev_ack),
      .output_bus (output_bus),
      .out_stb    (out_stb),
      .out_dev_hs (out_dev_hs),
      .out_dev_ack(out_dev_ack),
      .rx_data    (rx_data),
      .rx_empty   (rx_empty),
      .rx_rd      (rx_rd),
      .rx_ovf     (rx_ovf)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   // Processor model: wait for a byte, hold 2 cycles, ack, release 1 cycle later.
   task automatic proc_take(input logic [7:0] exp);
      int w;
      w = 0;
      while (!in_dev_hs && w < 10) begin
         step();
         w++;
      end
      check_eq("tx_hs_up", in_dev_hs, 1);
      check_eq("tx_byte", input_bus, exp);
      repeat (2) begin
         step();
         check_eq("tx_hold_hs", in_dev_hs, 1);
         check_eq("tx_hold_bus", input_bus, exp);
      end
      in_dev_ack = 1'b1;
      step();
      check_eq("tx_hs_fall", in_dev_hs, 0);
      step();
      in_dev_ack = 1'b0;
      step();
      check_eq("tx_idle_after_rel", in_dev_hs, 0);
   endtask

   task automatic rx_strobe(input logic [7:0] b);
      output_bus = b;
      out_stb    = 1'b1;
      step();
      out_stb    = 1'b0;
   endtask

   initial begin
      g_clr      = 1'b1;
      tx_data    = '0;
      tx_wr      = 1'b0;
      in_dev_ack = 1'b0;
      output_bus = '0;
      out_stb    = 1'b0;
      rx_rd      = 1'b0;
      #2 g_clr   = 1'b0;

      // Reset values
      repeat (2) step();
      check_eq("rst_input_bus", input_bus, 8'h00);
      check_eq("rst_in_dev_hs", in_dev_hs, 0);
      check_eq("rst_out_dev_hs", out_dev_hs, 0);
      check_eq("rst_out_dev_ack", out_dev_ack, 0);
      check_eq("rst_tx_full", tx_full, 0);
      check_eq("rst_rx_empty", rx_empty, 1);
      check_eq("rst_rx_data", rx_data, 8'h00);
      check_eq("rst_tx_ovf", tx_ovf, 0);
      check_eq("rst_rx_ovf", rx_ovf, 0);
      g_clr = 1'b1;
      check_eq("init_hs_low", out_dev_hs, 0);
      step();
      check_eq("init_hs_up", out_dev_hs, 1);

      // TX delivery with explicit latency checks on the first byte
      tx_data = 8'h3C;
      tx_wr   = 1'b1;
      step();
      tx_data = 8'hA5;
      check_eq("tx_lat_hs0", in_dev_hs, 0);
      step();
      tx_wr = 1'b0;
      check_eq("tx_lat_hs1", in_dev_hs, 1);
      check_eq("tx_lat_bus", input_bus, 8'h3C);
      repeat (2) begin
         step();
         check_eq("tx_3c_hold", input_bus, 8'h3C);
      end
      in_dev_ack = 1'b1;
      step();
      check_eq("tx_3c_fall", in_dev_hs, 0);
      step();
      check_eq("tx_wait_rel", in_dev_hs, 0);
      in_dev_ack = 1'b0;
      step();
      check_eq("tx_no_early", in_dev_hs, 0);
      proc_take(8'hA5);

      // TX full and overflow
      for (int i = 1; i <= 5; i++) begin
         tx_data = 8'(i);
         tx_wr   = 1'b1;
         step();
         if (i == 3) check_eq("tx_full_3", tx_full, 0);
         if (i == 4) begin
            check_eq("tx_full_4", tx_full, 1);
            check_eq("tx_ovf_4", tx_ovf, 0);
         end
      end
      tx_wr = 1'b0;
      check_eq("tx_ovf_5", tx_ovf, 1);
      check_eq("tx_full_5", tx_full, 1);
      for (int i = 1; i <= 4; i++) proc_take(8'(i));
      check_eq("tx_full_drained", tx_full, 0);
      repeat (4) begin
         step();
         check_eq("tx_no_05", in_dev_hs, 0);
      end

      // RX capture
      check_eq("rx_hs_ready", out_dev_hs, 1);
      rx_strobe(8'h7E);
      check_eq("rx_ack_on", out_dev_ack, 1);
      check_eq("rx_data_7e", rx_data, 8'h7E);
      check_eq("rx_nonempty", rx_empty, 0);
      check_eq("rx_hs_ackcyc", out_dev_hs, 0);
      step();
      check_eq("rx_ack_off", out_dev_ack, 0);
      check_eq("rx_hs_back", out_dev_hs, 1);
      rx_rd = 1'b1;
      step();
      rx_rd = 1'b0;
      check_eq("rx_empty_pop", rx_empty, 1);
      check_eq("rx_ovf_clean", rx_ovf, 0);

      // RX full
      rx_strobe(8'h11); step();
      rx_strobe(8'h22); step();
      rx_strobe(8'h33); step();
      rx_strobe(8'h44); step();
      check_eq("rxf_hs_low", out_dev_hs, 0);
      check_eq("rxf_head", rx_data, 8'h11);
      check_eq("rxf_ovf0", rx_ovf, 0);
      rx_strobe(8'h55);
      check_eq("rxf_ovf1", rx_ovf, 1);
      check_eq("rxf_no_ack", out_dev_ack, 0);
      check_eq("rxf_head_kept", rx_data, 8'h11);
      rx_rd = 1'b1;
      step();
      rx_rd = 1'b0;
      check_eq("rxf_hs_reraise", out_dev_hs, 1);
      check_eq("rxf_head_22", rx_data, 8'h22);
      rx_rd = 1'b1;
      step();
      check_eq("rxf_head_33", rx_data, 8'h33);
      step();
      check_eq("rxf_head_44", rx_data, 8'h44);
      step();
      rx_rd = 1'b0;
      check_eq("rxf_empty_no55", rx_empty, 1);

      // Reset in the middle of a handshake
      output_bus = 8'h99;
      out_stb    = 1'b1;
      tx_data    = 8'h0A;
      tx_wr      = 1'b1;
      step();
      out_stb = 1'b0;
      tx_data = 8'h0B;
      step();
      tx_data = 8'h0C;
      step();
      tx_wr = 1'b0;
      check_eq("mid_hs_up", in_dev_hs, 1);
      check_eq("mid_bus", input_bus, 8'h0A);
      check_eq("mid_rx_full", rx_empty, 0);
      #1 g_clr = 1'b0;
      #1;
      check_eq("mid_hs_async", in_dev_hs, 0);
      check_eq("mid_ack_async", out_dev_ack, 0);
      check_eq("mid_rx_empty", rx_empty, 1);
      check_eq("mid_bus_clr", input_bus, 8'h00);
      check_eq("mid_tx_ovf_clr", tx_ovf, 0);
      check_eq("mid_rx_ovf_clr", rx_ovf, 0);
      #1 g_clr = 1'b1;
      repeat (5) begin
         step();
         check_eq("mid_no_stale", in_dev_hs, 0);
      end
      check_eq("mid_out_hs", out_dev_hs, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
